// File: rtl/gpu_sched_pkg.sv
// Shared types and helpers for the wave scheduler: slot/FSM encodings and the
// modulo-NUM_WAVES pointer increment used by the round-robin search.
package gpu_sched_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_READY = 2'd1,
    SLOT_WAIT  = 2'd2
  } slot_state_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_SELECT   = 2'd2,
    ST_ISSUE    = 2'd3
  } fsm_state_e;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/wave_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requesting slot after rr_ptr,
// wrapping from NUM_WAVES-1 back to 0 (NUM_WAVES need not be a power of two).
module rr_arbiter
  import gpu_sched_pkg::*;
#(
  parameter int NUM_WAVES = 5,
  parameter int WID_W     = $clog2(NUM_WAVES)
) (
  input  logic [NUM_WAVES-1:0] req,
  input  logic [WID_W-1:0]     rr_ptr,
  output logic [WID_W-1:0]     grant,
  output logic                 any_grant
);

  always_comb begin
    int unsigned idx;
    grant     = '0;
    any_grant = 1'b0;
    idx       = 32'(rr_ptr);
    for (int i = 0; i < NUM_WAVES; i++) begin
      idx = rr_next(idx, NUM_WAVES);
      if (!any_grant && req[idx[WID_W-1:0]]) begin
        any_grant = 1'b1;
        grant     = idx[WID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wave_scheduler.sv
// Per-SIMD wave scheduler: allocates context slots to incoming waves, picks one
// READY wave per issue round (round-robin) and sequences the PC context block.
module wave_scheduler
  import gpu_sched_pkg::*;
#(
  parameter  int NUM_WAVES = 5,
  localparam int WID_W     = $clog2(NUM_WAVES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispatch_req,
  output logic             dispatch_ack,
  output logic [WID_W-1:0] dispatch_wid,
  output logic [WID_W-1:0] active_context,
  output logic             dispatch_new_wave,
  output logic             update_pc,
  output logic             issue_valid,
  input  logic             issue_ready,
  input  logic             instr_is_mem,
  input  logic             instr_is_exit,
  input  logic             mem_done,
  input  logic [WID_W-1:0] mem_done_wid,
  output logic             wave_retired,
  output logic [WID_W-1:0] retired_wid,
  output logic [WID_W:0]   num_active
);

  fsm_state_e       state_q;
  slot_state_e      slot_q [NUM_WAVES];
  logic [WID_W-1:0] rr_ptr_q;
  logic [WID_W-1:0] ctx_q;
  logic [WID_W-1:0] dispatch_wid_q;
  logic             dispatch_ack_q;
  logic             new_wave_q;
  logic             issue_valid_q;
  logic [WID_W:0]   num_active_q;

  logic [NUM_WAVES-1:0] ready_vec;
  logic                 free_any;
  logic [WID_W-1:0]     free_id;
  logic [WID_W-1:0]     grant;
  logic                 any_grant;
  logic                 hs;

  // Descending scan so the lowest-index FREE slot wins.
  always_comb begin
    ready_vec = '0;
    free_any  = 1'b0;
    free_id   = '0;
    for (int i = NUM_WAVES - 1; i >= 0; i--) begin
      ready_vec[i] = (slot_q[i] == SLOT_READY);
      if (slot_q[i] == SLOT_FREE) begin
        free_any = 1'b1;
        free_id  = WID_W'(i);
      end
    end
  end

  rr_arbiter #(
    .NUM_WAVES(NUM_WAVES),
    .WID_W    (WID_W)
  ) u_arb (
    .req      (ready_vec),
    .rr_ptr   (rr_ptr_q),
    .grant    (grant),
    .any_grant(any_grant)
  );

  assign hs = issue_valid_q & issue_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      for (int i = 0; i < NUM_WAVES; i++) slot_q[i] <= SLOT_FREE;
      rr_ptr_q       <= WID_W'(NUM_WAVES - 1);
      ctx_q          <= '0;
      dispatch_wid_q <= '0;
      dispatch_ack_q <= 1'b0;
      new_wave_q     <= 1'b0;
      issue_valid_q  <= 1'b0;
      num_active_q   <= '0;
    end else begin
      // Memory completion may land in any state; the FSM writes below win on
      // the same slot, which can only happen for a slot that is not WAIT.
      if (mem_done && (32'(mem_done_wid) < NUM_WAVES) && slot_q[mem_done_wid] == SLOT_WAIT)
        slot_q[mem_done_wid] <= SLOT_READY;

      case (state_q)
        ST_IDLE: begin
          if (dispatch_req && free_any) begin
            state_q        <= ST_DISPATCH;
            ctx_q          <= free_id;
            dispatch_wid_q <= free_id;
            dispatch_ack_q <= 1'b1;
            new_wave_q     <= 1'b1;
          end else if (|ready_vec) begin
            state_q <= ST_SELECT;
          end
        end
        ST_DISPATCH: begin
          slot_q[ctx_q]  <= SLOT_READY;
          num_active_q   <= num_active_q + 1'b1;
          dispatch_wid_q <= '0;
          dispatch_ack_q <= 1'b0;
          new_wave_q     <= 1'b0;
          state_q        <= ST_IDLE;
        end
        ST_SELECT: begin
          if (any_grant) begin
            ctx_q         <= grant;
            rr_ptr_q      <= grant;
            issue_valid_q <= 1'b1;
            state_q       <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            if (instr_is_exit) begin
              slot_q[ctx_q] <= SLOT_FREE;
              num_active_q  <= num_active_q - 1'b1;
            end else if (instr_is_mem) begin
              slot_q[ctx_q] <= SLOT_WAIT;
            end
            issue_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // During SELECT the chosen slot is presented immediately so the PC block can
  // reload pc_out before ISSUE.
  assign active_context    = (state_q == ST_SELECT) ? grant : ctx_q;
  assign dispatch_ack      = dispatch_ack_q;
  assign dispatch_wid      = dispatch_wid_q;
  assign dispatch_new_wave = new_wave_q;
  assign issue_valid       = issue_valid_q;
  assign update_pc         = hs;
  assign wave_retired      = hs & instr_is_exit;
  assign retired_wid       = (hs & instr_is_exit) ? ctx_q : '0;
  assign num_active        = num_active_q;

endmodule

// File: tb/tb_wave_scheduler.sv
// Directed bench for wave_scheduler: dispatch, round-robin issue, memory park,
// full-slot backpressure with retire, wraparound and asynchronous reset abort.
module tb_wave_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dispatch_req = 1'b0;
  logic       dispatch_ack;
  logic [2:0] dispatch_wid;
  logic [2:0] active_context;
  logic       dispatch_new_wave;
  logic       update_pc;
  logic       issue_valid;
  logic       issue_ready = 1'b0;
  logic       instr_is_mem = 1'b0;
  logic       instr_is_exit = 1'b0;
  logic       mem_done = 1'b0;
  logic [2:0] mem_done_wid = 3'd0;
  logic       wave_retired;
  logic [2:0] retired_wid;
  logic [3:0] num_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wave_scheduler #(.NUM_WAVES(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .dispatch_req     (dispatch_req),
    .dispatch_ack     (dispatch_ack),
    .dispatch_wid     (dispatch_wid),
    .active_context   (active_context),
    .dispatch_new_wave(dispatch_new_wave),
    .update_pc        (update_pc),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .instr_is_mem     (instr_is_mem),
    .instr_is_exit    (instr_is_exit),
    .mem_done         (mem_done),
    .mem_done_wid     (mem_done_wid),
    .wave_retired     (wave_retired),
    .retired_wid      (retired_wid),
    .num_active       (num_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    dispatch_req = 1'b0; issue_ready = 1'b0; instr_is_mem = 1'b0;
    instr_is_exit = 1'b0; mem_done = 1'b0; mem_done_wid = 3'd0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic dispatch_one(input logic [2:0] exp_wid);
    bit ok = 1'b0;
    dispatch_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (dispatch_ack === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dispatch_timeout: no dispatch_ack, expected wid %0d", exp_wid);
    end else if (dispatch_wid !== exp_wid || active_context !== exp_wid || dispatch_new_wave !== 1'b1) begin
      errors++;
      $display("FAIL dispatch_ack: wid=%0d ctx=%0d new_wave=%b, expected wid=%0d ctx=%0d new_wave=1",
               dispatch_wid, active_context, dispatch_new_wave, exp_wid, exp_wid);
    end
  endtask

  task automatic issue_one(input logic [2:0] exp_wid, input logic mem, input logic ext);
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (issue_valid === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_timeout: issue_valid never rose, expected wave %0d", exp_wid);
      return;
    end
    if (active_context !== exp_wid) begin
      errors++;
      $display("FAIL issue_order: active_context=%0d expected %0d", active_context, exp_wid);
    end
    issue_ready = 1'b1; instr_is_mem = mem; instr_is_exit = ext;
    #1;
    checks++;
    if (update_pc !== 1'b1 || wave_retired !== ext || retired_wid !== (ext ? exp_wid : 3'd0)) begin
      errors++;
      $display("FAIL issue_handshake: update_pc=%b retired=%b rwid=%0d expected update_pc=1 retired=%b rwid=%0d",
               update_pc, wave_retired, retired_wid, ext, ext ? exp_wid : 3'd0);
    end
    step();
    issue_ready = 1'b0; instr_is_mem = 1'b0; instr_is_exit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if ({dispatch_ack, dispatch_wid, active_context, dispatch_new_wave, update_pc,
         issue_valid, wave_retired, retired_wid, num_active} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b wid=%0d ctx=%0d nw=%b upc=%b iv=%b ret=%b rwid=%0d na=%0d, expected all 0",
               dispatch_ack, dispatch_wid, active_context, dispatch_new_wave, update_pc,
               issue_valid, wave_retired, retired_wid, num_active);
    end
  endtask

  task automatic test_dispatch();
    reset_dut();
    dispatch_one(3'd0);
    dispatch_one(3'd1);
    dispatch_req = 1'b0;
    step();
    checks++;
    if (num_active !== 4'd2 || dispatch_ack !== 1'b0) begin
      errors++;
      $display("FAIL dispatch_count: num_active=%0d ack=%b expected 2 and 0", num_active, dispatch_ack);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
    int last_cyc = 0;
    reset_dut();
    dispatch_one(3'd0);
    dispatch_one(3'd1);
    dispatch_one(3'd2);
    dispatch_req = 1'b0;
    issue_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      bit ok = 1'b0;
      for (int k = 0; k < 12; k++) begin
        step();
        if (update_pc === 1'b1) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rr_timeout: no update_pc for issue %0d", n);
      end else if (active_context !== exp_seq[n]) begin
        errors++;
        $display("FAIL rr_order: issue %0d wave=%0d expected %0d", n, active_context, exp_seq[n]);
      end
      if (ok && n > 0) begin
        checks++;
        if (cyc - last_cyc != 3) begin
          errors++;
          $display("FAIL rr_latency: gap=%0d cycles expected 3", cyc - last_cyc);
        end
      end
      last_cyc = cyc;
    end
    step();
    issue_ready = 1'b0;
  endtask

  task automatic test_mem_wait();
    reset_dut();
    dispatch_one(3'd0);
    dispatch_one(3'd1);
    dispatch_one(3'd2);
    dispatch_req = 1'b0;
    issue_one(3'd0, 1'b0, 1'b0);
    issue_one(3'd1, 1'b1, 1'b0);
    issue_one(3'd2, 1'b0, 1'b0);
    issue_one(3'd0, 1'b0, 1'b0);
    issue_one(3'd2, 1'b0, 1'b0);
    issue_one(3'd0, 1'b0, 1'b0);
    mem_done = 1'b1; mem_done_wid = 3'd1;
    step();
    mem_done = 1'b0;
    issue_one(3'd1, 1'b0, 1'b0);
    issue_one(3'd2, 1'b0, 1'b0);
    issue_one(3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_full_retire();
    bit acked = 1'b0;
    reset_dut();
    for (int w = 0; w < 5; w++) dispatch_one(3'(w));
    for (int k = 0; k < 6; k++) begin
      step();
      if (dispatch_ack !== 1'b0) acked = 1'b1;
    end
    checks++;
    if (acked || num_active !== 4'd5) begin
      errors++;
      $display("FAIL full_backpressure: ack_seen=%b num_active=%0d expected 0 and 5", acked, num_active);
    end
    issue_one(3'd0, 1'b0, 1'b0);
    issue_one(3'd1, 1'b0, 1'b0);
    issue_one(3'd2, 1'b0, 1'b0);
    issue_one(3'd3, 1'b0, 1'b1);
    checks++;
    if (num_active !== 4'd4) begin
      errors++;
      $display("FAIL retire_count: num_active=%0d expected 4", num_active);
    end
    dispatch_one(3'd3);
    dispatch_req = 1'b0;
    step();
    checks++;
    if (num_active !== 4'd5) begin
      errors++;
      $display("FAIL redispatch_count: num_active=%0d expected 5", num_active);
    end
  endtask

  task automatic test_wraparound();
    reset_dut();
    for (int w = 0; w < 5; w++) dispatch_one(3'(w));
    dispatch_req = 1'b0;
    issue_one(3'd0, 1'b1, 1'b0);
    issue_one(3'd1, 1'b1, 1'b0);
    issue_one(3'd2, 1'b1, 1'b0);
    issue_one(3'd3, 1'b1, 1'b0);
    issue_one(3'd4, 1'b0, 1'b0);
    mem_done = 1'b1; mem_done_wid = 3'd0;
    step();
    mem_done = 1'b0;
    issue_one(3'd0, 1'b0, 1'b0);
    issue_one(3'd4, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    bit ok = 1'b0;
    bit bad = 1'b0;
    reset_dut();
    dispatch_one(3'd0);
    dispatch_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (issue_valid === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_setup: issue_valid=%b expected 1", issue_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({dispatch_ack, dispatch_wid, active_context, dispatch_new_wave, update_pc,
         issue_valid, wave_retired, retired_wid, num_active} !== 18'd0) begin
      errors++;
      $display("FAIL abort_outputs: ctx=%0d upc=%b iv=%b na=%0d expected all 0",
               active_context, update_pc, issue_valid, num_active);
    end
    issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (update_pc !== 1'b0) bad = 1'b1;
    end
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (update_pc !== 1'b0 || issue_valid !== 1'b0 || num_active !== 4'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_no_issue: update_pc=%b issue_valid=%b num_active=%0d expected 0 0 0",
               update_pc, issue_valid, num_active);
    end
    issue_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_round_robin();
    test_mem_wait();
    test_full_retire();
    test_wraparound();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_scheduler.md
Name: wave_scheduler

Overview:
- Per-SIMD-unit controller that owns the wave slots and sequences the per-wave PC context block.
- Accepts new waves from the workgroup dispatcher and allocates each to a free context slot.
- Picks one READY wave per issue round using round-robin and drives active_context, dispatch_new_wave and update_pc to the PC block.
- Parks waves waiting on memory and frees each slot when its wave executes an exit instruction.

Parameters:
- NUM_WAVES, 5, number of wave context slots per SIMD unit; need not be a power of two.
- WID_W, $clog2(NUM_WAVES), width of a wave/context id; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- dispatch_req  in  1  dispatcher has a new wave; held until dispatch_ack.
- dispatch_ack  out  1  one-cycle pulse: the wave was accepted into slot dispatch_wid.
- dispatch_wid  out  WID_W  slot allocated; valid only while dispatch_ack=1.
- active_context  out  WID_W  context select to the PC block.
- dispatch_new_wave  out  1  to the PC block: zero the PC of active_context.
- update_pc  out  1  to the PC block: increment the PC of active_context.
- issue_valid  out  1  the PC block's pc_out for active_context is valid; fetch/issue may proceed.
- issue_ready  in  1  fetch/issue accepted the instruction this cycle.
- instr_is_mem  in  1  the accepted instruction is a memory op; qualified by issue_valid&issue_ready.
- instr_is_exit  in  1  the accepted instruction ends the wave; qualified by issue_valid&issue_ready.
- mem_done  in  1  the memory op of wave mem_done_wid has completed.
- mem_done_wid  in  WID_W  wave id for mem_done.
- wave_retired  out  1  one-cycle pulse when a slot is freed.
- retired_wid  out  WID_W  slot freed; valid with wave_retired.
- num_active  out  WID_W+1  count of slots not FREE.

Behaviour:
- Slot state, one per wave: FREE, READY or WAIT.
- Reset (rst=0, asynchronous):
  - all slots FREE; FSM in IDLE.
  - rr_ptr = NUM_WAVES-1, so the first search starts at slot 0.
  - every output is 0.
- FSM states: IDLE, DISPATCH, SELECT, ISSUE.
- IDLE:
  - If dispatch_req and a free slot exists: go to DISPATCH; latch the lowest-index FREE slot.
  - Else if any slot is READY: go to SELECT.
  - Dispatch takes priority over issue.
- DISPATCH (1 cycle):
  - Drive active_context = latched slot, dispatch_new_wave=1, dispatch_ack=1, dispatch_wid = slot.
  - Slot becomes READY.
  - Return to IDLE.
- SELECT (1 cycle):
  - Choose the first READY slot scanning rr_ptr+1, rr_ptr+2, … modulo NUM_WAVES, wrapping from NUM_WAVES-1 to 0.
  - Drive active_context = chosen slot, with update_pc=0 and dispatch_new_wave=0, so the PC block reloads pc_out.
  - Set rr_ptr = chosen slot; go to ISSUE.
  - If no slot is READY, because a mem_done race resolved the other way, go back to IDLE.
- ISSUE:
  - Hold active_context; issue_valid=1.
  - On issue_valid&issue_ready, in the same cycle:
    - update_pc=1.
    - If instr_is_exit: slot → FREE, wave_retired=1, retired_wid = slot.
    - Else if instr_is_mem: slot → WAIT.
    - Else: slot stays READY.
    - Next state IDLE.
  - With no handshake: stay in ISSUE; all other outputs hold.
  - instr_is_exit has priority over instr_is_mem.
- Issue latency: at least 3 cycles per instruction (IDLE→SELECT→ISSUE with issue_ready=1).
- mem_done:
  - Any cycle, including during ISSUE of another wave: slot mem_done_wid goes WAIT→READY at the next edge.
  - mem_done on a slot not in WAIT is ignored; it has no effect.
- All slots occupied: dispatch_ack stays 0 and dispatch_req waits. A slot freed by retire is allocatable from the next IDLE.
- dispatch_req while in ISSUE: not serviced until the FSM returns to IDLE.
- num_active is registered and updates on the cycle after dispatch or retire.
- Deasserting rst mid-ISSUE aborts the instruction: no update_pc, all waves lost. The dispatcher must re-dispatch.

Decomposition:
- Shared package gpu_sched_pkg:
  - slot state enum (FREE=2'd0, READY=2'd1, WAIT=2'd2).
  - FSM state enum.
  - function rr_next for modulo-NUM_WAVES increment.
- One natural sub-module: rr_arbiter.
  - Inputs: NUM_WAVES-bit request vector and rr_ptr.
  - Outputs: grant id and any_grant.
  - Purely combinational.
- Implementation note: the PC block uses an active-high synchronous reset, so the integrating top must invert rst for it.

Test Plan:
1. Reset then dispatch_req=1 for 3 cycles → dispatch_ack with wid 0. Then after requeue, ack with wid 1. Each ack coincides with dispatch_new_wave=1 and active_context equal to the ack wid. num_active ends at 2.
2. Three READY waves, issue_ready=1, no mem/exit → issued order 0,1,2,0,1,…. Each handshake cycle has update_pc=1, and each issue is exactly 3 cycles apart.
3. Wave 1 issues with instr_is_mem=1 → subsequent order is 2,0,2,0. Pulse mem_done with wid 1 → wave 1 reappears in the next round after rr_ptr passes.
4. Fill all 5 slots, then hold dispatch_req=1 → no ack. Retire wave 3 via instr_is_exit → wave_retired with wid 3, then ack with wid 3. num_active goes 5→4→5.
5. NUM_WAVES=5 wraparound with only wave 4 and wave 0 READY and rr_ptr=4 → wave 0 is selected next, then wave 4.
6. Deassert rst while in ISSUE with issue_ready=0 → all outputs 0 asynchronously, num_active=0, and no update_pc pulse is observed.
